// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed 7-segment driver for packed BCD digits.
// Snapshots bcd_in on load, then scans the digits one at a time. Each slot is
// SCAN_DIV clocks: one blank guard clock followed by SCAN_DIV-1 lit clocks.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (d>0, this and every higher digit == 0)
//   are decoded as blank segments; digit 0 is never blanked.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   bcd_in     in   packed BCD, digit d = bcd_in[4d+3:4d]
//   load       in   capture bcd_in into the snapshot on this edge
//   seg        out  {g,f,e,d,c,b,a}, active-high, registered
//   dig_en     out  one-hot digit enable, active-high, registered
//   frame_tick out  one-clock pulse when the scan index wraps to digit 0
module bcd_seg_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_snap;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic                    r_frame_tick;

    logic                    w_div_wrap;
    logic                    w_idx_last;
    logic [DIV_W-1:0]        w_div_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_seg_dec;
    logic [6:0]              w_seg_nxt;

    // BCD to {g,f,e,d,c,b,a}; non-decimal codes blank the digit
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Prescaler and scan index next state
    always_comb begin
        w_div_wrap = (r_div_cnt == DIV_LAST);
        w_idx_last = (r_idx == IDX_LAST);
        w_div_nxt  = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
        w_idx_nxt  = r_idx;
        if (w_div_wrap) begin
            w_idx_nxt = w_idx_last ? '0 : r_idx + IDX_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;
    logic                  w_blank_sel;

    // Digit d is blank when it and every more significant digit are zero
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int d = int'(NUM_DIGITS) - 1; d >= 1; d--) begin
            w_zero_run = w_zero_run & (r_snap[4*d +: 4] == 4'd0);
            w_blank[d] = w_zero_run;
        end
    end
`endif

    // Select the active digit and build the one-hot enable
    always_comb begin
        w_digit  = '0;
        w_onehot = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_sel = 1'b0;
`endif
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_digit     = r_snap[4*d +: 4];
                w_onehot[d] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank_sel = w_blank[d];
`endif
            end
        end
    end

    always_comb begin
        w_seg_dec = seg_decode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        w_seg_nxt = w_blank_sel ? 7'h00 : w_seg_dec;
`else
        w_seg_nxt = w_seg_dec;
`endif
    end

    // State and registered outputs; load never touches the scan timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap       <= '0;
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_seg        <= 7'h00;
            r_dig_en     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (load) begin
                r_snap <= bcd_in;
            end
            r_div_cnt    <= w_div_nxt;
            r_idx        <= w_idx_nxt;
            r_seg        <= w_seg_nxt;
            // div_cnt==0 is the guard clock that separates digits
            r_dig_en     <= (r_div_cnt == '0) ? '0 : w_onehot;
            r_frame_tick <= w_div_wrap & w_idx_last;
        end
    end

    assign seg        = r_seg;
    assign dig_en     = r_dig_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (NUM_DIGITS=4, SCAN_DIV=4) plus a
// single-digit instance fed by a BCD counter.
module tb_bcd_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] bcd_in;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    logic [3:0]  bcd1;
    logic        load1;
    logic [6:0]  seg1;
    logic [0:0]  dig_en1;
    logic        frame_tick1;

    bcd_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    bcd_seg_scan #(.NUM_DIGITS(1), .SCAN_DIV(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd1), .load(load1),
        .seg(seg1), .dig_en(dig_en1), .frame_tick(frame_tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;

    // Reference state for the 4-digit instance
    logic [15:0] m_snap;
    int          m_div;
    int          m_idx;
    logic [11:0] q_exp[$];
    logic [6:0]  obs_seg[4];

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_snap = 16'h0;
        m_div  = 0;
        m_idx  = 0;
        q_exp.delete();
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 4; d++) obs_seg[d] = 7'bx;
        n_ticks = 0;
    endtask

    // One clock: push expected outputs for this edge, advance model, compare
    task automatic cycle(input logic ld, input logic [15:0] bv, input string tag);
        logic [6:0]  es;
        logic [3:0]  ed;
        logic        et;
        logic [11:0] ex;
        logic [15:0] hi;
        load   = ld;
        bcd_in = bv;
        es = dec(m_snap[4*m_idx +: 4]);
        hi = m_snap >> (4*m_idx);
        if (LZB && m_idx > 0 && hi == 16'h0) es = 7'h00;
        ed = (m_div == 0) ? 4'b0000 : 4'(1 << m_idx);
        et = (m_div == 3 && m_idx == 3);
        q_exp.push_back({es, ed, et});
        if (ld) m_snap = bv;
        if (m_div == 3) begin
            m_div = 0;
            m_idx = (m_idx == 3) ? 0 : m_idx + 1;
        end else begin
            m_div++;
        end
        @(posedge clk);
        #1;
        ex = q_exp.pop_front();
        n_checks++;
        if ({seg, dig_en, frame_tick} !== ex) begin
            n_errors++;
            $display("FAIL %s seg/dig_en/tick got %h/%b/%b want %h/%b/%b",
                     tag, seg, dig_en, frame_tick, ex[11:5], ex[4:1], ex[0]);
        end
        if (frame_tick) n_ticks++;
        for (int d = 0; d < 4; d++) if (dig_en == 4'(1 << d)) obs_seg[d] = seg;
    endtask

    task automatic check_digits(input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3,
                                input string tag);
        logic [6:0] ev[4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (obs_seg[d] !== ev[d]) begin
                n_errors++;
                $display("FAIL %s digit%0d seg got %h want %h", tag, d, obs_seg[d], ev[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load = 1'b0; bcd_in = 16'h0; load1 = 1'b0; bcd1 = 4'h0;
        #3;
        n_checks++;
        if ({seg, dig_en, frame_tick} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_state got %h/%b/%b want 00/0000/0", seg, dig_en, frame_tick);
        end
        repeat (2) @(posedge clk);
        #4 reset_n = 1'b1;
        model_reset();
    endtask

    // digits 4,3,2,1 in slots 0..3, one frame_tick per 16 clocks
    task automatic test_scan_1234();
        clear_obs();
        cycle(1'b1, 16'h1234, "t2_load");
        for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, "t2_scan");
        clear_obs();
        for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, "t2_scan");
        check_digits(7'h66, 7'h4F, 7'h5B, 7'h06, "t2_digits");
        n_checks++;
        if (n_ticks != 1) begin
            n_errors++;
            $display("FAIL t2_tick_count got %0d want 1", n_ticks);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, "t1_pre");
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({seg, dig_en, frame_tick} !== 12'h000) begin
            n_errors++;
            $display("FAIL t1_async_clear got %h/%b/%b want 00/0000/0", seg, dig_en, frame_tick);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({seg, dig_en, frame_tick} !== 12'h000) begin
            n_errors++;
            $display("FAIL t1_held got %h/%b/%b want 00/0000/0", seg, dig_en, frame_tick);
        end
        #3 reset_n = 1'b1;
        model_reset();
        cycle(1'b0, 16'h0, "t1_guard");
        n_checks++;
        if (dig_en !== 4'b0000) begin
            n_errors++;
            $display("FAIL t1_first_guard dig_en got %b want 0000", dig_en);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0, "t1_lit");
            n_checks++;
            if (dig_en !== 4'b0001) begin
                n_errors++;
                $display("FAIL t1_first_lit dig_en got %b want 0001", dig_en);
            end
        end
    endtask

    task automatic test_invalid_codes();
        cycle(1'b1, 16'h9A0F, "t3_load");
        for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0, "t3_scan");
        clear_obs();
        for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, "t3_scan");
        check_digits(7'h00, 7'h3F, 7'h00, 7'h6F, "t3_digits");
    endtask

    task automatic test_load_on_wrap();
        int guard;
        cycle(1'b1, 16'h1234, "t4_load1");
        guard = 0;
        while (!(m_div == 3 && m_idx == 3) && guard < 20) begin
            cycle(1'b0, 16'h0, "t4_run");
            guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_errors++;
            $display("FAIL t4_find_wrap got timeout want wrap within 20 clocks");
        end
        cycle(1'b1, 16'h5678, "t4_load2");
        n_checks++;
        if (frame_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL t4_tick_on_load got %b want 1", frame_tick);
        end
        cycle(1'b0, 16'h0, "t4_guard");
        cycle(1'b0, 16'h0, "t4_digit0");
        n_checks++;
        if (dig_en !== 4'b0001 || seg !== 7'h7F) begin
            n_errors++;
            $display("FAIL t4_new_digit0 got %h/%b want 7f/0001", seg, dig_en);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] ez;
        ez = LZB ? 7'h00 : 7'h3F;
        cycle(1'b1, 16'h0050, "t5_load");
        for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0, "t5_scan");
        clear_obs();
        for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, "t5_scan");
        check_digits(7'h3F, 7'h6D, ez, ez, "t5_digits");
    endtask

    // Single-digit instance tracking a free-running BCD counter
    task automatic test_single_digit();
        logic [6:0] q1[$];
        logic [6:0] e;
        logic [3:0] q;
        int t1, lit1;
        q = 4'd0; t1 = 0; lit1 = 0;
        for (int k = 0; k < 24; k++) begin
            bcd1  = q;
            load1 = 1'b1;
            q1.push_back(dec(q));
            cycle(1'b0, 16'h0, "t6_main");
            if (q1.size() > 1) begin
                e = q1.pop_front();
                n_checks++;
                if (seg1 !== e) begin
                    n_errors++;
                    $display("FAIL t6_track k=%0d seg got %h want %h", k, seg1, e);
                end
            end
            if (k >= 4) begin
                if (frame_tick1) t1++;
                if (dig_en1 == 1'b1) lit1++;
            end
            q = (q == 4'd9) ? 4'd0 : q + 4'd1;
        end
        load1 = 1'b0;
        n_checks++;
        if (t1 != 5 || lit1 != 15) begin
            n_errors++;
            $display("FAIL t6_ticks got %0d/%0d want 5/15", t1, lit1);
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_mid_reset();
        test_invalid_codes();
        test_load_on_wrap();
        test_leading_zero();
        test_single_digit();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
